// File: rtl/reg_scan_pkg.sv
// Shared types and constants for the reg_scan_8b channel sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package reg_scan_pkg;

    // Width of one mux channel word.
    localparam int CH_W = 8;

    // Number of mux channels fed by the register bank.
    localparam int N_CH = 4;

    // Highest select value; a transfer here ends a pass.
    localparam logic [1:0] SEL_LAST = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [N_CH-1:0][CH_W-1:0] bank_t;

    // Select step with natural wrap 3 -> 0.
    function automatic logic [1:0] sel_step(input logic [1:0] sel);
        return sel + 2'd1;
    endfunction

endpackage

// File: rtl/reg_scan_8b_reg4x8.sv
// Four-entry 8-bit channel register bank with a single write port.
// Latency: a write lands on the edge that samples it; contents readable the cycle after.
// Backpressure: none; writes are dropped while i_wr_inhibit is high.
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high clear of all entries
//   i_wr_en/addr/data  write strobe, channel index (0=A..3=D), write data
//   i_wr_inhibit       drops writes (the sequencer holds this high mid-scan)
//   o_q                current register contents, packed [3:0][7:0]
//   o_live             per channel, the value the register holds after the coming
//                      edge is usable for a transfer. With SKIP_ZERO_EN defined this
//                      is "non-zero"; otherwise every channel is always live.
module reg4x8
    import reg_scan_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [1:0]       i_wr_addr,
    input  logic [CH_W-1:0]  i_wr_data,
    input  logic             i_wr_inhibit,
    output bank_t            o_q,
    output logic [N_CH-1:0]  o_live
);

    bank_t r_q;
    bank_t w_nxt;

    // Next contents: current value with the accepted write merged in.
    always_comb begin
        w_nxt = r_q;
        if (i_wr_en && !i_wr_inhibit) begin
            w_nxt[i_wr_addr] = i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_nxt;
        end
    end

    assign o_q = r_q;

    // Look-ahead on w_nxt so a Start that coincides with a write sees the
    // freshly written word when deciding whether channel 0 is skipped.
`ifdef SKIP_ZERO_EN
    always_comb begin
        o_live = '0;
        for (int i = 0; i < N_CH; i++) begin
            o_live[i] = |w_nxt[i];
        end
    end
`else
    assign o_live = '1;
`endif

endmodule

// File: rtl/reg_scan_8b.sv
// Sequencer driving an 8-bit 4:1 mux: holds channels A-D and streams them by stepping Sel.
// Latency: Sel/Valid valid the cycle after Start; Done 4*NPASS cycles after SCAN entry at full rate.
// Backpressure: Ready low holds Sel and Valid indefinitely; skipped channels advance regardless.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   WrEn/WrAddr/WrData    channel register write port (accepted in IDLE and DONE only)
//   Start                 single-cycle scan request (honoured in IDLE only, never queued)
//   Ready                 downstream accepts the word on mux output F this cycle
//   A, B, C, D            channel registers, wired to the mux data inputs
//   Sel                   mux select = current channel
//   Valid                 F holds a word to transfer
//   Busy                  high while scanning
//   Done                  one-cycle pulse when the scan completes
//
// Optional feature: SKIP_ZERO_EN -- channels holding 8'h00 are stepped over
// with Valid low for one cycle instead of being presented.
module reg_scan_8b
    import reg_scan_pkg::*;
#(
    parameter int NPASS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             WrEn,
    input  logic [1:0]       WrAddr,
    input  logic [CH_W-1:0]  WrData,
    input  logic             Start,
    input  logic             Ready,
    output logic [CH_W-1:0]  A,
    output logic [CH_W-1:0]  B,
    output logic [CH_W-1:0]  C,
    output logic [CH_W-1:0]  D,
    output logic [1:0]       Sel,
    output logic             Valid,
    output logic             Busy,
    output logic             Done
);

    localparam logic [3:0] PASS_LAST = 4'(NPASS - 1);

    state_t            r_state;
    logic [1:0]        r_sel;
    logic [3:0]        r_pass;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    bank_t             w_q;
    logic [N_CH-1:0]   w_live;
    logic              w_wr_inhibit;
    logic              w_adv;
    logic              w_last;
    logic [1:0]        w_sel_inc;

    // Registers must not change under the consumer while a scan is running.
    assign w_wr_inhibit = (r_state == SCAN);

    reg4x8 u_bank (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_wr_en      (WrEn),
        .i_wr_addr    (WrAddr),
        .i_wr_data    (WrData),
        .i_wr_inhibit (w_wr_inhibit),
        .o_q          (w_q),
        .o_live       (w_live)
    );

    // A presented word moves on only with Ready; a skipped slot (Valid low
    // while scanning) always moves on after its single cycle.
    assign w_adv     = (r_state == SCAN) && (!r_valid || Ready);
    assign w_last    = (r_sel == SEL_LAST) && (r_pass == PASS_LAST);
    assign w_sel_inc = sel_step(r_sel);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sel   <= 2'd0;
            r_pass  <= 4'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_state <= SCAN;
                        r_sel   <= 2'd0;
                        r_pass  <= 4'd0;
                        r_busy  <= 1'b1;
                        r_valid <= w_live[0];
                    end
                end

                SCAN: begin
                    if (w_adv) begin
                        if (w_last) begin
                            r_state <= DONE;
                            r_sel   <= 2'd0;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_sel   <= w_sel_inc;
                            if (r_sel == SEL_LAST) begin
                                r_pass <= r_pass + 4'd1;
                            end
                            // Writes are inhibited here, so w_live reflects the
                            // stable register contents of the next channel.
                            r_valid <= w_live[w_sel_inc];
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_sel   <= 2'd0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign A     = w_q[0];
    assign B     = w_q[1];
    assign C     = w_q[2];
    assign D     = w_q[3];
    assign Sel   = r_sel;
    assign Valid = r_valid;
    assign Busy  = r_busy;
    assign Done  = r_done;

endmodule

// File: doc/reg_scan_8b.md
# reg_scan_8b

Upstream driver for the 8-bit 4:1 mux (`mux4t1_8b`). It holds four 8-bit channel registers that drive the mux data inputs A–D, and steps the mux `Sel` through the channels after a start pulse. Each selected word is presented to the mux consumer with a valid/ready handshake. The block is the sequencer that turns the combinational mux into a serial 4-word stream.

## Interface
Parameters:
- NPASS, default 1: full 0→3 passes per Start; legal range 1–15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- WrEn  in  1  write strobe for the channel registers.
- WrAddr  in  2  channel index to write (0=A … 3=D).
- WrData  in  8  data to write.
- Start  in  1  single-cycle request to begin a scan.
- Ready  in  1  downstream consumer of mux F accepts the current word.
- A, B, C, D  out  8 each  channel registers; wired to mux inputs A–D.
- Sel  out  2  mux select; its value is the current channel.
- Valid  out  1  the mux output F, selected by Sel, holds a word to transfer.
- Busy  out  1  high while in SCAN.
- Done  out  1  one-cycle pulse when the scan completes.

## Operation
- The FSM has three states: IDLE, SCAN, DONE. Reset enters IDLE.
- Reset values: A=B=C=D=8'h00, Sel=0, Valid=0, Busy=0, Done=0, pass counter=0.
- Writes are accepted only in IDLE and DONE. In those states, WrEn=1 loads WrData into the register selected by WrAddr on the next edge. WrEn is ignored in SCAN, so registers stay stable mid-scan.
- IDLE:
  - Start=1 → SCAN, with Sel=0 and pass=0.
  - Start=1 together with WrEn=1 in the same cycle: the write lands first, and the scan uses the new value.
- SCAN:
  - Busy=1 and Valid=1.
  - A transfer occurs on a cycle where Valid=1 and Ready=1.
  - After a transfer, Sel increments with wrap from 3 to 0. On the wrap, pass increments.
  - If the transfer happens at Sel=3 and pass=NPASS-1 → DONE.
  - Ready=0 holds Sel and Valid indefinitely.
- DONE: Done=1, Busy=0, Valid=0, Sel returns to 0. Next cycle → IDLE unconditionally.
- Start is ignored in SCAN and DONE; it is not queued.
- Reset mid-scan forces the full reset state on the next edge. No Done is produced, and register contents are cleared.

## Timing
- Start is sampled at edge N. Busy, Valid, and Sel=0 are visible after edge N.
- Transfer rate is 1 word/cycle when Ready is held high.
- Start to Done (Ready held high): Done asserts 4·NPASS cycles after entry to SCAN, and lasts exactly one cycle.
- The earliest re-Start is accepted in the cycle after Done, in IDLE.
- Valid and Sel are registered outputs. The data path F is combinational through the mux from the A–D registers.

## Configuration
- SKIP_ZERO_EN, when defined:
  - In SCAN, a channel whose register equals 8'h00 is skipped. For one cycle Valid=0 and Sel advances regardless of Ready.
  - Pass and termination rules are unchanged. If Sel=3 is skipped on the final pass, the FSM goes to DONE.
  - If all four registers are zero, the scan takes 4·NPASS cycles with Valid never high, then Done pulses.
- SKIP_ZERO_EN undefined: every channel is presented, including zero words.

## Structure
- Package reg_scan_pkg holds:
  - the state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2);
  - SEL_LAST=2'd3;
  - the channel width constant 8.
- Sub-module reg4x8 is the write-port register bank (WrEn/WrAddr/WrData, reset clear, write-inhibit input from the FSM).
- The FSM, Sel counter, and pass counter live in the top module.

## Test plan
- Reset, then write A=8'h11, B=8'h22, C=8'h33, D=8'h44; Start with Ready=1 and NPASS=1 → Sel steps 0,1,2,3 on consecutive cycles with F=11,22,33,44; Done pulses in the 5th cycle after Start.
- Same setup with Ready low for 3 cycles at Sel=2 → Sel holds at 2 and Valid stays 1; stream resumes with 33 then 44; total cycles extended by 3.
- NPASS=2 → 8 transfers in order 11,22,33,44,11,22,33,44, then a single Done.
- WrEn to channel B=8'hFF during SCAN → ignored, B stays 22; Start asserted during SCAN → no restart and no second Done.
- Reset asserted at Sel=1 mid-scan → after the next edge all outputs are 0 and state is IDLE; no Done pulse.
- SKIP_ZERO_EN with B=8'h00 → transfers are 11,33,44 with one Valid=0 cycle at Sel=1; with all registers zero → no Valid and Done after 4 cycles.
